// File: rtl/execute_branch_unit_if.sv
// execute_branch_unit_if: issue/result handshake, flush and perf counter bundle for the branch unit
interface execute_branch_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1_val;
  logic [XLEN-1:0]  in_rs2_val;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rd_val;
  logic             out_rd_write;
  logic [XLEN-1:0]  out_pc;
  logic             out_jump;
  logic             out_exception_valid;
  logic [5:0]       out_exception_num;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_taken;
  modport master (
    output flush, in_valid, in_opcode, in_funct3, in_imm, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_rd_val, out_rd_write, out_pc, out_jump,
           out_exception_valid, out_exception_num, perf_branches, perf_taken
  );
  modport slave (
    input  flush, in_valid, in_opcode, in_funct3, in_imm, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_rd_val, out_rd_write, out_pc, out_jump,
           out_exception_valid, out_exception_num, perf_branches, perf_taken
  );
endinterface

// File: rtl/execute_branch_unit.sv
// execute_branch_unit: resolves JAL/JALR/conditional branches into a single registered result slot
module execute_branch_unit #(
  parameter int XLEN  = 32,
  parameter int C_EXT = 0,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  execute_branch_unit_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;
  logic [2:0] f3;
  logic [XLEN-1:0] link, jalr_sum, tgt, pc_d, rd_val_q, pc_q;
  logic is_jal, is_jalr, is_br, legal, cond, taken, mis, exc, accept, retire;
  logic rd_write_d, jump_d, rd_write_q, jump_q, exc_q, is_br_q;
  logic [5:0] exc_num_q;
  logic [CNT_W-1:0] br_q, tk_q;
  assign f3 = bus.in_funct3;
  always_comb begin
    is_jal   = bus.in_opcode == 7'b1101111;
    is_jalr  = bus.in_opcode == 7'b1100111;
    is_br    = bus.in_opcode == 7'b1100011;
    link     = bus.in_pc + XLEN'(4);
    jalr_sum = bus.in_rs1_val + bus.in_imm;
    cond     = (f3[2:1] == 2'b00 ? bus.in_rs1_val == bus.in_rs2_val :
                f3[2:1] == 2'b10 ? $signed(bus.in_rs1_val) < $signed(bus.in_rs2_val) :
                bus.in_rs1_val < bus.in_rs2_val) ^ f3[0];
    legal    = is_jal || (is_jalr && f3 == 3'b000) || (is_br && f3[2:1] != 2'b01);
    taken    = legal && (is_jal || is_jalr || cond);
    tgt      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.in_pc + bus.in_imm;
    mis      = taken && (C_EXT != 0 ? tgt[0] : |tgt[1:0]);
    exc      = !legal || mis;
    pc_d     = taken ? tgt : link;
    jump_d   = taken && !exc;
    rd_write_d = jump_d && !is_br;
  end
  // A flush kills both the same-cycle accept and the same-cycle retirement
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign retire = state_q == FULL && bus.out_ready && !bus.flush && is_br_q && !exc_q;
  always_comb begin
    state_d = state_q;
    state_d = bus.flush ? EMPTY : accept ? FULL : (state_q == FULL && bus.out_ready) ? EMPTY : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_val_q   <= '0;
      pc_q       <= '0;
      rd_write_q <= 1'b0;
      jump_q     <= 1'b0;
      exc_q      <= 1'b0;
      exc_num_q  <= '0;
      is_br_q    <= 1'b0;
    end else if (accept) begin
      rd_val_q   <= link;
      pc_q       <= pc_d;
      rd_write_q <= rd_write_d;
      jump_q     <= jump_d;
      exc_q      <= exc;
      exc_num_q  <= legal ? 6'd0 : 6'd2;
      is_br_q    <= is_br;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_q <= '0;
      tk_q <= '0;
    end else if (retire) begin
      br_q <= br_q + CNT_W'(1);
      tk_q <= tk_q + CNT_W'(jump_q);
    end
  end
  assign bus.in_ready            = state_q == EMPTY || bus.out_ready;
  assign bus.out_valid           = state_q == FULL;
  assign bus.out_rd_val          = rd_val_q;
  assign bus.out_pc              = pc_q;
  assign bus.out_rd_write        = rd_write_q;
  assign bus.out_jump            = jump_q;
  assign bus.out_exception_valid = exc_q;
  assign bus.out_exception_num   = exc_num_q;
  assign bus.perf_branches       = br_q;
  assign bus.perf_taken          = tk_q;
endmodule

// File: tb/tb_execute_branch_unit.sv
// tb_execute_branch_unit: random + directed checks of two branch units (C_EXT=0 and 1) against a mnemonic-level model
module tb_execute_branch_unit;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd;
    logic        rdw;
    logic        jump;
    logic        exc;
    logic [5:0]  num;
  } out_t;
  typedef struct packed {
    out_t o;
    logic is_br;
    logic taken;
  } res_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1, chk_en = 0;
  logic [6:0] op = 0;
  logic [2:0] f3 = 0;
  logic [31:0] imm = 0, pc = 0, rs1 = 0, rs2 = 0;
  int errors = 0, checks = 0;
  logic m_valid;
  res_t m_out [2];
  logic [31:0] m_br [2], m_tk [2];
  out_t g [2];
  execute_branch_unit_if #(.XLEN(32), .CNT_W(32)) bus0 ();
  execute_branch_unit_if #(.XLEN(32), .CNT_W(32)) bus1 ();
  execute_branch_unit #(.XLEN(32), .C_EXT(0), .CNT_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  execute_branch_unit #(.XLEN(32), .C_EXT(1), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  always #5 clk = ~clk;
  assign {bus0.flush, bus0.in_valid, bus0.out_ready, bus0.in_opcode, bus0.in_funct3} = {flush, in_valid, out_ready, op, f3};
  assign {bus1.flush, bus1.in_valid, bus1.out_ready, bus1.in_opcode, bus1.in_funct3} = {flush, in_valid, out_ready, op, f3};
  assign {bus0.in_imm, bus0.in_pc, bus0.in_rs1_val, bus0.in_rs2_val} = {imm, pc, rs1, rs2};
  assign {bus1.in_imm, bus1.in_pc, bus1.in_rs1_val, bus1.in_rs2_val} = {imm, pc, rs1, rs2};
  assign g[0] = {bus0.out_pc, bus0.out_rd_val, bus0.out_rd_write, bus0.out_jump, bus0.out_exception_valid, bus0.out_exception_num};
  assign g[1] = {bus1.out_pc, bus1.out_rd_val, bus1.out_rd_write, bus1.out_jump, bus1.out_exception_valid, bus1.out_exception_num};

  function automatic res_t model(int cext, logic [6:0] o, logic [2:0] f, logic [31:0] im, p, a, b);
    res_t r;
    logic legal, tk;
    logic [31:0] t;
    r = '0;
    r.o.rd = p + 4;
    r.o.pc = p + 4;
    legal = 1;
    tk = 0;
    t = p + im;
    case (o)
      JAL: tk = 1;
      JALR: begin legal = (f == 0); tk = 1; t = (a + im) & 32'hFFFF_FFFE; end
      BR: begin
        r.is_br = 1;
        case (f)
          0: tk = (a == b);
          1: tk = (a != b);
          4: tk = ($signed(a) < $signed(b));
          5: tk = ($signed(a) >= $signed(b));
          6: tk = (a < b);
          7: tk = (a >= b);
          default: legal = 0;
        endcase
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      r.o.exc = 1;
      r.o.num = 2;
    end else if (tk) begin
      r.taken = 1;
      r.o.pc = t;
      if ((cext != 0) ? (t % 2 != 0) : (t % 4 != 0)) r.o.exc = 1;
      else begin
        r.o.jump = 1;
        r.o.rdw = !r.is_br;
      end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0;
      for (int c = 0; c < 2; c++) begin m_out[c] = '0; m_br[c] = 0; m_tk[c] = 0; end
    end else if (flush) m_valid = 0;
    else begin
      if (m_valid && out_ready)
        for (int c = 0; c < 2; c++)
          if (m_out[c].is_br && !m_out[c].o.exc) begin
            m_br[c]++;
            if (m_out[c].taken) m_tk[c]++;
          end
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1;
        for (int c = 0; c < 2; c++) m_out[c] = model(c, op, f3, imm, pc, rs1, rs2);
      end else if (m_valid && out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("out_valid0", bus0.out_valid, m_valid);
    chk("out_valid1", bus1.out_valid, m_valid);
    chk("in_ready", bus0.in_ready, !m_valid || out_ready);
    for (int c = 0; c < 2; c++) begin
      if (m_valid) begin
        chk($sformatf("out_pc%0d", c), g[c].pc, m_out[c].o.pc);
        chk($sformatf("out_rd_val%0d", c), g[c].rd, m_out[c].o.rd);
        chk($sformatf("out_rd_write%0d", c), g[c].rdw, m_out[c].o.rdw);
        chk($sformatf("out_jump%0d", c), g[c].jump, m_out[c].o.jump);
        chk($sformatf("exc_valid%0d", c), g[c].exc, m_out[c].o.exc);
        if (m_out[c].o.exc) chk($sformatf("exc_num%0d", c), g[c].num, m_out[c].o.num);
      end
    end
    chk("perf_branches0", bus0.perf_branches, m_br[0]);
    chk("perf_taken0", bus0.perf_taken, m_tk[0]);
    chk("perf_branches1", bus1.perf_branches, m_br[1]);
    chk("perf_taken1", bus1.perf_taken, m_tk[1]);
  end

  task automatic cyc(); @(negedge clk); #1; endtask
  task automatic set_in(logic v, logic [6:0] o, logic [2:0] f, logic [31:0] im, p, a, b);
    in_valid = v; op = o; f3 = f; imm = im; pc = p; rs1 = a; rs2 = b;
  endtask
  task automatic issue(logic [6:0] o, logic [2:0] f, logic [31:0] im, p, a, b);
    set_in(1, o, f, im, p, a, b);
    cyc();
    in_valid = 0;
  endtask

  initial begin
    int k;
    repeat (3) cyc();
    rst_n = 1;
    chk_en = 1;
    chk("rst_valid", bus0.out_valid, 0);
    chk("rst_pc", bus0.out_pc, 0);
    chk("rst_rd", bus0.out_rd_val, 0);
    chk("rst_flags", {bus0.out_rd_write, bus0.out_jump, bus0.out_exception_valid, bus0.out_exception_num}, 0);
    issue(JAL, 0, 32'h20, 32'h100, 0, 0);
    chk("jal_pc", bus0.out_pc, 32'h120);
    chk("jal_rd", bus0.out_rd_val, 32'h104);
    chk("jal_rdw_jump_exc", {bus0.out_rd_write, bus0.out_jump, bus0.out_exception_valid}, 3'b110);
    issue(JALR, 0, 0, 32'h500, 32'h2003, 0);
    chk("jalr0_pc", bus0.out_pc, 32'h2002);
    chk("jalr0_exc", {bus0.out_exception_valid, bus0.out_exception_num, bus0.out_jump}, {1'b1, 6'd0, 1'b0});
    chk("jalr1_jump_exc", {bus1.out_jump, bus1.out_exception_valid}, 2'b10);
    issue(BR, 3'b100, 32'hFFFF_FFF8, 32'h40, 32'hFFFF_FFFF, 1);
    chk("blt_pc", bus0.out_pc, 32'h38);
    chk("blt_jump", bus0.out_jump, 1);
    issue(BR, 3'b110, 32'hFFFF_FFF8, 32'h40, 32'hFFFF_FFFF, 1);
    chk("bltu_pc", bus0.out_pc, 32'h44);
    chk("bltu_jump", bus0.out_jump, 0);
    issue(BR, 3'b010, 32'h10, 32'h80, 5, 5);
    chk("br010_exc", {bus0.out_exception_valid, bus0.out_exception_num}, {1'b1, 6'd2});
    chk("br010_pc", bus0.out_pc, 32'h84);
    issue(7'b0110011, 0, 32'h10, 32'h90, 0, 0);
    chk("op33_exc", {bus0.out_exception_valid, bus0.out_exception_num, bus0.out_rd_write}, {1'b1, 6'd2, 1'b0});
    cyc();
    out_ready = 0;
    issue(JAL, 0, 8, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", bus0.in_ready, 0);
      chk("bp_pc_stable", bus0.out_pc, 32'h208);
      cyc();
    end
    out_ready = 1;
    set_in(1, JAL, 0, 4, 32'h300, 0, 0);
    #1 chk("bp_in_ready_up", bus0.in_ready, 1);
    cyc();
    in_valid = 0;
    chk("b2b_valid", bus0.out_valid, 1);
    chk("b2b_pc", bus0.out_pc, 32'h304);
    out_ready = 0;
    cyc();
    flush = 1;
    set_in(1, JAL, 0, 4, 32'h400, 0, 0);
    cyc();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", bus0.out_valid, 0);
    cyc();
    chk("flush_dropped", bus0.out_valid, 0);
    out_ready = 1;
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      set_in(1, BR, i < 5 ? 3'b000 : 3'b001, 32'h10, 32'h1000, 7, 7);
      cyc();
    end
    in_valid = 0;
    repeat (2) cyc();
    chk("perf_branches7", bus0.perf_branches, 7);
    chk("perf_taken5", bus0.perf_taken, 5);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("rst_perf", {bus0.perf_branches, bus0.perf_taken}, 0);
    chk("rst_valid2", bus0.out_valid, 0);
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      op = k < 5 ? BR : k < 7 ? JAL : k < 9 ? JALR : 7'($urandom);
      f3 = (op == JALR && $urandom_range(0, 3) != 0) ? 3'b000 : 3'($urandom);
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) imm[1:0] = 2'b00;
      pc = $urandom;
      pc[1:0] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rs1 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      cyc();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
